bcd_encode: RTL and testbench

Converts a two-digit packed BCD value (tens nibble, units nibble) into a 7-bit binary count. It is the inverse of the registered binary-to-BCD decoder, and sits on the input side of the display/count path, where BCD entered from keys or switches must become a binary `num` again. Conversion is multi-cycle shift-add (tens×8 + tens×2 + units) behind a valid/ready handshake, so no multiplier is needed. Out-of-range or non-BCD input is flagged rather than converted.

---
 rtl/bcd_encode.sv | 106 ++++++++++
 tb/tb_bcd_encode.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_encode.sv
// Packed two-digit BCD to 7-bit binary via shift-add; legal result 4 cycles after accept, error result 1 cycle.
// Result registers hold while out_ready is low; in_ready stays low from accept until the result is consumed.
module bcd_encode #(
    parameter int         MAX_VAL = 81,
    parameter logic [6:0] ERR_NUM = 7'd127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] BCD_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] num,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        ADD1  = 3'd3,
        ADD2  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] MAX_Q = 8'(MAX_VAL);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] bcd_q;
    logic [6:0] acc;
    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] dec_val;
    logic       bad;

    assign tens  = bcd_q[7:4];
    assign units = bcd_q[3:0];

    // 8 bits covers the worst non-BCD nibble pair (15*10+15) so the range compare never wraps.
    assign dec_val = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {4'b0000, units};
    assign bad     = (tens > 4'd9) || (units > 4'd9) || (dec_val > MAX_Q);

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CHECK;
            CHECK:   state_nxt = bad ? DONE : MUL;
            MUL:     state_nxt = ADD1;
            ADD1:    state_nxt = ADD2;
            ADD2:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q     <= 8'd0;
            acc       <= 7'd0;
            num       <= 7'd0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) bcd_q <= BCD_code;
                end
                CHECK: begin
                    if (bad) begin
                        num       <= ERR_NUM;
                        err       <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                MUL: begin
                    acc <= {tens, 3'b000};
                end
                ADD1: begin
                    acc <= acc + {2'b00, tens, 1'b0};
                end
                ADD2: begin
                    num       <= acc + {3'b000, units};
                    err       <= 1'b0;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_encode.sv
// Bench for bcd_encode: cycle-level transaction model plus directed and random stimulus.
module tb_bcd_encode;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] BCD_code;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] num;
    logic       err;

    logic       v99;
    logic       rdy99;
    logic [7:0] c99;
    logic       ov99;
    logic [6:0] num99;
    logic       err99;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_encode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .BCD_code(BCD_code), .out_valid(out_valid), .out_ready(out_ready),
        .num(num), .err(err)
    );

    bcd_encode #(.MAX_VAL(99)) dut99 (
        .clk(clk), .rst_n(rst_n), .in_valid(v99), .in_ready(rdy99),
        .BCD_code(c99), .out_valid(ov99), .out_ready(1'b1),
        .num(num99), .err(err99)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: {err, num}.
    function automatic logic [7:0] ref_conv(input logic [7:0] code, input int maxv);
        int t;
        int u;
        t = int'(code[7:4]);
        u = int'(code[3:0]);
        if (t > 9 || u > 9 || t * 10 + u > maxv) return {1'b1, 7'd127};
        return {1'b0, 7'(t * 10 + u)};
    endfunction

    // Transaction model: a pending countdown to the result, then a hold until consumed.
    int         m_pend = 0;
    bit         m_ov = 0;
    bit         m_started = 0;
    logic [6:0] m_num = '0;
    logic       m_err = 1'b0;
    logic [7:0] p_res = '0;
    logic [7:0] acc_res;

    assign acc_res = ref_conv(BCD_code, 81);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started <= 1;
            m_pend    <= 0;
            m_ov      <= 0;
            m_num     <= '0;
            m_err     <= 1'b0;
        end else if (m_pend != 0) begin
            m_pend <= m_pend - 1;
            if (m_pend == 1) begin
                m_ov  <= 1;
                m_num <= p_res[6:0];
                m_err <= p_res[7];
            end
        end else if (m_ov) begin
            if (out_ready) m_ov <= 0;
        end else if (in_valid) begin
            p_res  <= acc_res;
            m_pend <= acc_res[7] ? 1 : 4;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", int'(in_ready), int'(m_pend == 0 && !m_ov));
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("num", int'(num), int'(m_num));
            chk("err", int'(err), int'(m_err));
        end
    end

    // Drive one transaction on the selected instance and check its result and latency.
    task automatic send(input string name, input bit sel, input logic [7:0] code,
                        input int exp_num, input int exp_err, input int exp_lat,
                        input bit busy);
        int guard;
        int lat;
        guard = 0;
        while (!(sel ? rdy99 : in_ready) && guard < 50) begin
            @(posedge clk) #2;
            guard++;
        end
        chk({name, "_ready_wait"}, int'(guard < 50), 1);
        if (sel) begin v99 = 1'b1; c99 = code; end
        else begin in_valid = 1'b1; BCD_code = code; end
        @(posedge clk) #2;
        if (sel) begin
            v99 = 1'b0; c99 = 8'($urandom);
        end else if (busy) begin
            BCD_code = 8'h11;
        end else begin
            in_valid = 1'b0; BCD_code = 8'($urandom);
        end
        lat = 0;
        while (!(sel ? ov99 : out_valid) && lat < 20) begin
            @(posedge clk) #2;
            lat++;
        end
        in_valid = 1'b0;
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_num"}, int'(sel ? num99 : num), exp_num);
        chk({name, "_err"}, int'(sel ? err99 : err), exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'($urandom);
        BCD_code  = 8'($urandom);
        out_ready = 1'($urandom);
        v99       = 1'b0;
        c99       = 8'h00;

        @(posedge clk) #2;
        chk("rst_in_ready", int'(in_ready), 1);
        in_valid = 1'($urandom); BCD_code = 8'($urandom); out_ready = 1'($urandom);
        @(posedge clk) #2;
        chk("rst_num", int'(num), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        @(posedge clk) #2;
        chk("post_rst_out_valid", int'(out_valid), 0);

        send("leg00", 0, 8'h00, 0, 0, 4, 0);
        send("leg09", 0, 8'h09, 9, 0, 4, 0);
        send("leg10", 0, 8'h10, 10, 0, 4, 0);
        send("leg47", 0, 8'h47, 47, 0, 4, 0);
        send("leg81", 0, 8'h81, 81, 0, 4, 0);

        send("err82", 0, 8'h82, 127, 1, 1, 0);
        send("err99", 0, 8'h99, 127, 1, 1, 0);
        send("err0A", 0, 8'h0A, 127, 1, 1, 0);
        send("errA0", 0, 8'hA0, 127, 1, 1, 0);
        send("errBB", 0, 8'hBB, 127, 1, 1, 0);

        send("m99_99", 1, 8'h99, 99, 0, 4, 0);
        send("m99_82", 1, 8'h82, 82, 0, 4, 0);
        send("m99_A0", 1, 8'hA0, 127, 1, 1, 0);

        out_ready = 1'b0;
        send("bp35", 0, 8'h35, 35, 0, 4, 0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_num", int'(num), 35);
            chk("bp_in_ready", int'(in_ready), 0);
            @(posedge clk) #2;
        end
        out_ready = 1'b1;
        @(posedge clk) #2;
        chk("bp_release", int'(out_valid), 0);
        send("bp12", 0, 8'h12, 12, 0, 4, 0);

        send("busy53", 0, 8'h53, 53, 0, 4, 1);

        while (!in_ready) @(posedge clk) #2;
        in_valid = 1'b1; BCD_code = 8'h64;
        @(posedge clk) #2;
        in_valid = 1'b0;
        @(posedge clk) #2;
        @(posedge clk) #2;
        rst_n = 1'b0;
        @(posedge clk) #2;
        rst_n = 1'b1;
        chk("midrst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_out", int'(out_valid), 0);
            @(posedge clk) #2;
        end

        for (int n = 0; n <= 81; n++) begin
            send("roundtrip", 0, {4'(n / 10), 4'(n % 10)}, n, 0, 4, 0);
        end

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            BCD_code  = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                        : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk) #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk) #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
